// File: rtl/pe_ram_port_arbiter_if.sv
// Requester-side bus of the PE scratch RAM arbiter.
// Flat buses: requester i owns bit i of req/req_we/gnt/rvalid and slice i of
// req_addr/req_wdata/rdata.
//   master : requesters (drive req, req_we, req_addr, req_wdata; see gnt, rvalid, rdata)
//   slave  : arbiter    (sees requests; drives gnt, rvalid, rdata)
interface pe_ram_port_arbiter_if #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NREQ-1:0]            req;
    logic [NREQ-1:0]            req_we;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*DATA_WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]            gnt;
    logic [NREQ-1:0]            rvalid;
    logic [NREQ*DATA_WIDTH-1:0] rdata;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/pe_ram_port_arbiter.sv
// Round-robin arbiter sharing one true-dual-port PE scratch RAM (1-cycle
// registered read) among NREQ requesters. Up to two grants per cycle: the
// first winner in search order goes to port A, the second to port B. A second
// winner that hits the same address as the first while either of them writes
// is held off to the next cycle. Read data returns one cycle after the grant,
// tagged to the requester that issued the read.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       requester bus: req/req_we/req_addr/req_wdata in,
//                     gnt (combinational), rvalid/rdata out
//   wea/addrA/dinA    RAM port A controls, doutA registered read data
//   web/addrB/dinB    RAM port B controls, doutB registered read data
module pe_ram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NREQ       = 4,
    parameter int unsigned IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    pe_ram_port_arbiter_if.slave  bus,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addrA,
    output logic [DATA_WIDTH-1:0] dinA,
    input  logic [DATA_WIDTH-1:0] doutA,
    output logic                  web,
    output logic [ADDR_WIDTH-1:0] addrB,
    output logic [DATA_WIDTH-1:0] dinB,
    input  logic [DATA_WIDTH-1:0] doutB
);
    // Request vectors padded to the full index space so any IDX_W-bit index is
    // in range; padding slots never request.
    localparam int unsigned NSLOT = 2 ** IDX_W;

    logic [NSLOT-1:0]      req_ext;
    logic [NSLOT-1:0]      we_ext;
    logic [ADDR_WIDTH-1:0] addr_ext  [NSLOT];
    logic [DATA_WIDTH-1:0] wdata_ext [NSLOT];

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             rd_a_vld_q, rd_b_vld_q;
    logic [IDX_W-1:0] rd_a_idx_q, rd_b_idx_q;

    logic             a_hit, b_hit;
    logic [IDX_W-1:0] a_idx, b_idx, scan_idx;
    logic             b_conflict;
    logic             grant_a, grant_b;
    logic [NSLOT-1:0] gnt_ext;

    logic [NREQ-1:0]            rvalid_c;
    logic [NREQ*DATA_WIDTH-1:0] rdata_c;

    // Unpack the flat requester buses.
    always_comb begin
        req_ext = '0;
        we_ext  = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            addr_ext[i]  = '0;
            wdata_ext[i] = '0;
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ext[i]   = bus.req[i];
            we_ext[i]    = bus.req_we[i];
            addr_ext[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_ext[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan rr_ptr, rr_ptr+1, ... mod NREQ; first hit is winner A, second is B.
    always_comb begin
        a_hit    = 1'b0;
        b_hit    = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = IDX_W'((32'(rr_ptr_q) + k) % NREQ);
            if (req_ext[scan_idx]) begin
                if (!a_hit) begin
                    a_hit = 1'b1;
                    a_idx = scan_idx;
                end else if (!b_hit) begin
                    b_hit = 1'b1;
                    b_idx = scan_idx;
                end
            end
        end
    end

    // Same address with any write on either side would race inside the RAM;
    // two reads of one address are harmless.
    assign b_conflict = (addr_ext[a_idx] == addr_ext[b_idx]) && (we_ext[a_idx] || we_ext[b_idx]);
    assign grant_a    = a_hit && !rst;
    assign grant_b    = b_hit && !b_conflict && !rst;

    // RAM port drive and grant vector; idle ports are held at zero.
    always_comb begin
        gnt_ext = '0;
        wea     = 1'b0;
        addrA   = '0;
        dinA    = '0;
        web     = 1'b0;
        addrB   = '0;
        dinB    = '0;
        if (grant_a) begin
            gnt_ext[a_idx] = 1'b1;
            wea            = we_ext[a_idx];
            addrA          = addr_ext[a_idx];
            dinA           = wdata_ext[a_idx];
        end
        if (grant_b) begin
            gnt_ext[b_idx] = 1'b1;
            web            = we_ext[b_idx];
            addrB          = addr_ext[b_idx];
            dinB           = wdata_ext[b_idx];
        end
    end

    assign bus.gnt = gnt_ext[NREQ-1:0];

    // Pointer moves just past the last index granted this cycle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_b) begin
            rr_ptr_d = IDX_W'((32'(b_idx) + 1) % NREQ);
        end else if (grant_a) begin
            rr_ptr_d = IDX_W'((32'(a_idx) + 1) % NREQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            rd_a_vld_q <= 1'b0;
            rd_a_idx_q <= '0;
            rd_b_vld_q <= 1'b0;
            rd_b_idx_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rd_a_vld_q <= grant_a && !we_ext[a_idx];
            rd_a_idx_q <= a_idx;
            rd_b_vld_q <= grant_b && !we_ext[b_idx];
            rd_b_idx_q <= b_idx;
        end
    end

    // Route the RAM's registered read data back to the tagged requester.
    // Gated by rst so a read in flight when reset hits never returns.
    always_comb begin
        rvalid_c = '0;
        rdata_c  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!rst && rd_a_vld_q && (rd_a_idx_q == IDX_W'(i))) begin
                rvalid_c[i]                       = 1'b1;
                rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = doutA;
            end else if (!rst && rd_b_vld_q && (rd_b_idx_q == IDX_W'(i))) begin
                rvalid_c[i]                       = 1'b1;
                rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = doutB;
            end
        end
    end

    assign bus.rvalid = rvalid_c;
    assign bus.rdata  = rdata_c;
endmodule

// File: tb/tb_pe_ram_port_arbiter.sv
// Bench for pe_ram_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all shadowed by a behavioural model checked every cycle.
module tb_pe_ram_port_arbiter;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned IDX_W = 3;

    logic clk = 1'b0;
    logic rst;
    logic ram_clr;
    always #5 clk = ~clk;

    pe_ram_port_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          wea, web;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] dinA, dinB, doutA, doutB;

    pe_ram_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NREQ      (NREQ),
        .IDX_W     (IDX_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .wea  (wea),
        .addrA(addrA),
        .dinA (dinA),
        .doutA(doutA),
        .web  (web),
        .addrB(addrB),
        .dinB (dinB),
        .doutB(doutB)
    );

    // True-dual-port RAM, registered read returning the pre-write contents.
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int j = 0; j < 2**AW; j++) ram[j] <= '0;
            doutA <= '0;
            doutB <= '0;
        end else begin
            if (wea) ram[addrA] <= dinA;
            if (web) ram[addrB] <= dinB;
            doutA <= ram[addrA];
            doutB <= ram[addrB];
        end
    end

    // Stimulus state, packed onto the interface.
    logic          s_req  [NREQ];
    logic          s_we   [NREQ];
    logic [AW-1:0] s_addr [NREQ];
    logic [DW-1:0] s_wd   [NREQ];

    always_comb begin
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]               = s_req[i];
            bus.req_we[i]            = s_we[i];
            bus.req_addr[i*AW +: AW] = s_addr[i];
            bus.req_wdata[i*DW +: DW] = s_wd[i];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory contents, rotating priority, reads due next cycle.
    logic [DW-1:0]   m_mem [2**AW];
    int              m_ptr = 0;
    logic [NREQ-1:0] m_rv = '0;
    logic [DW-1:0]   m_rd [NREQ];
    logic [NREQ-1:0] m_gnt_last = '0;
    logic            started = 1'b0;

    initial for (int j = 0; j < 2**AW; j++) m_mem[j] = '0;

    logic [NREQ-1:0]    e_gnt, e_rv, n_rv;
    logic [NREQ*DW-1:0] e_rdata;
    logic               e_wea, e_web;
    logic [AW-1:0]      e_addrA, e_addrB;
    logic [DW-1:0]      e_dinA, e_dinB;
    int                 na, nb, sidx;

    always @(negedge clk) begin
        if (started) begin
            e_gnt = '0; e_rv = '0; e_rdata = '0; n_rv = '0;
            e_wea = 1'b0; e_addrA = '0; e_dinA = '0;
            e_web = 1'b0; e_addrB = '0; e_dinB = '0;
            if (rst) begin
                m_ptr = 0;
                m_rv  = '0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (m_rv[i]) begin
                        e_rv[i] = 1'b1;
                        e_rdata[i*DW +: DW] = m_rd[i];
                    end
                end
                na = -1; nb = -1;
                for (int k = 0; k < NREQ; k++) begin
                    sidx = (m_ptr + k) % NREQ;
                    if (s_req[sidx]) begin
                        if (na < 0) na = sidx;
                        else if (nb < 0) nb = sidx;
                    end
                end
                if (nb >= 0 && s_addr[na] == s_addr[nb] && (s_we[na] || s_we[nb])) nb = -1;
                if (na >= 0) begin
                    e_gnt[na] = 1'b1;
                    e_wea = s_we[na]; e_addrA = s_addr[na]; e_dinA = s_wd[na];
                    if (!s_we[na]) begin n_rv[na] = 1'b1; m_rd[na] = m_mem[s_addr[na]]; end
                end
                if (nb >= 0) begin
                    e_gnt[nb] = 1'b1;
                    e_web = s_we[nb]; e_addrB = s_addr[nb]; e_dinB = s_wd[nb];
                    if (!s_we[nb]) begin n_rv[nb] = 1'b1; m_rd[nb] = m_mem[s_addr[nb]]; end
                end
                if (na >= 0 && s_we[na]) m_mem[s_addr[na]] = s_wd[na];
                if (nb >= 0 && s_we[nb]) m_mem[s_addr[nb]] = s_wd[nb];
                if (nb >= 0) m_ptr = (nb + 1) % NREQ;
                else if (na >= 0) m_ptr = (na + 1) % NREQ;
                m_rv = n_rv;
            end
            m_gnt_last = e_gnt;
            check("gnt",    64'(bus.gnt),    64'(e_gnt));
            check("wea",    64'(wea),        64'(e_wea));
            check("addrA",  64'(addrA),      64'(e_addrA));
            check("dinA",   64'(dinA),       64'(e_dinA));
            check("web",    64'(web),        64'(e_web));
            check("addrB",  64'(addrB),      64'(e_addrB));
            check("dinB",   64'(dinB),       64'(e_dinB));
            check("rvalid", 64'(bus.rvalid), 64'(e_rv));
            check("rdata",  64'(bus.rdata),  64'(e_rdata));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic we, input int a, input int d);
        s_req[i]  = r;
        s_we[i]   = we;
        s_addr[i] = AW'(a);
        s_wd[i]   = DW'(d);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ram_clr = 1'b1;
        clear_reqs();
        next_cycle();
        next_cycle();
        ram_clr = 1'b0;
        started = 1'b1;

        // Reset holds everything quiet even with every requester asking.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i, 0);
        #2;
        check("t1_rst_gnt",    64'(bus.gnt),    64'h0);
        check("t1_rst_wea",    64'(wea),        64'h0);
        check("t1_rst_web",    64'(web),        64'h0);
        check("t1_rst_rvalid", 64'(bus.rvalid), 64'h0);
        rst = 1'b0;
        #1;
        check("t1_first_gnt",  64'(bus.gnt),    64'b0011);
        next_cycle();

        // Dual write, then dual read of the same locations.
        do_reset();
        set_req(0, 1'b1, 1'b1, 3, 'h5A);
        set_req(2, 1'b1, 1'b1, 7, 'hC3);
        #2;
        check("t2_wr_gnt",   64'(bus.gnt), 64'b0101);
        check("t2_wr_wea",   64'(wea),     64'h1);
        check("t2_wr_addrA", 64'(addrA),   64'd3);
        check("t2_wr_dinA",  64'(dinA),    64'h5A);
        check("t2_wr_web",   64'(web),     64'h1);
        check("t2_wr_addrB", 64'(addrB),   64'd7);
        check("t2_wr_dinB",  64'(dinB),    64'hC3);
        next_cycle();
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 3, 0);
        set_req(3, 1'b1, 1'b0, 7, 0);
        #2;
        check("t2_rd_gnt", 64'(bus.gnt), 64'b1010);
        next_cycle();
        clear_reqs();
        #2;
        check("t2_rvalid", 64'(bus.rvalid),              64'b1010);
        check("t2_rdata1", 64'(bus.rdata[1*DW +: DW]),   64'h5A);
        check("t2_rdata3", 64'(bus.rdata[3*DW +: DW]),   64'hC3);

        // Write/read conflict on one address: the reader waits a cycle.
        do_reset();
        set_req(0, 1'b1, 1'b1, 10, 'h77);
        set_req(1, 1'b1, 1'b0, 10, 0);
        #2;
        check("t3_gnt",   64'(bus.gnt), 64'b0001);
        check("t3_web",   64'(web),     64'h0);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 0, 0);
        #2;
        check("t3_retry_gnt",   64'(bus.gnt), 64'b0010);
        check("t3_retry_addrA", 64'(addrA),   64'd10);
        next_cycle();
        clear_reqs();
        #2;
        check("t3_rvalid", 64'(bus.rvalid),            64'b0010);
        check("t3_rdata1", 64'(bus.rdata[1*DW +: DW]), 64'h77);

        // Two reads of one address are both granted.
        do_reset();
        set_req(2, 1'b1, 1'b1, 5, 'h3C);
        #2;
        check("t4_wr_gnt", 64'(bus.gnt), 64'b0100);
        next_cycle();
        clear_reqs();
        set_req(0, 1'b1, 1'b0, 5, 0);
        set_req(1, 1'b1, 1'b0, 5, 0);
        #2;
        check("t4_rd_gnt", 64'(bus.gnt), 64'b0011);
        next_cycle();
        clear_reqs();
        #2;
        check("t4_rvalid", 64'(bus.rvalid),            64'b0011);
        check("t4_rdata0", 64'(bus.rdata[0*DW +: DW]), 64'h3C);
        check("t4_rdata1", 64'(bus.rdata[1*DW +: DW]), 64'h3C);

        // Fairness with everyone requesting continuously.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i, 0);
        for (int c = 0; c < 8; c++) begin
            #2;
            check("t5_fair_gnt", 64'(bus.gnt), (c % 2 == 0) ? 64'b0011 : 64'b1100);
            next_cycle();
        end

        // Reset while a read is in flight drops the return.
        do_reset();
        set_req(2, 1'b1, 1'b0, 3, 0);
        #2;
        check("t6_gnt", 64'(bus.gnt), 64'b0100);
        next_cycle();
        clear_reqs();
        rst = 1'b1;
        #2;
        check("t6_rvalid_in_rst", 64'(bus.rvalid), 64'h0);
        next_cycle();
        rst = 1'b0;
        #2;
        check("t6_rvalid_after", 64'(bus.rvalid), 64'h0);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i, 0);
        #1;
        check("t6_ptr_reset_gnt", 64'(bus.gnt), 64'b0011);
        next_cycle();

        // Randomized traffic: requests held until granted, narrow address range
        // to provoke conflicts, occasional resets.
        clear_reqs();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            for (int i = 0; i < NREQ; i++) begin
                if (s_req[i] && m_gnt_last[i]) s_req[i] = 1'b0;
                if (!s_req[i] && $urandom_range(0, 99) < 55) begin
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 255)));
                end
            end
            next_cycle();
        end

        rst = 1'b0;
        clear_reqs();
        repeat (3) next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
